// File: rtl/frame_peak_pkg.sv
// Shared widths and FSM encoding for the frame peak detector.
package frame_peak_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

endpackage

// File: rtl/frame_peak_detector_cmp.sv
// Unsigned 16-bit magnitude comparator: exactly one of gt/lt/eq is high.
module frame_peak_detector_cmp
    import frame_peak_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              gt,
    output logic              lt,
    output logic              eq
);

    assign gt = (a > b);
    assign lt = (a < b);
    assign eq = (a == b);

endmodule

// File: rtl/frame_peak_detector.sv
// Per-frame max/min/max-count tracker with valid/ready on both sides.
module frame_peak_detector
    import frame_peak_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_max,
    output logic [DATA_W-1:0] out_min,
    output logic [CNT_W-1:0]  out_max_count
);

    localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] max_reg, max_nxt;
    logic [DATA_W-1:0] min_reg, min_nxt;
    logic [CNT_W-1:0]  max_count, max_count_nxt;
    logic [CNT_W-1:0]  sample_cnt, sample_cnt_nxt;

    logic x_gt, x_lt, x_eq;
    logic n_gt, n_lt, n_eq;

    frame_peak_detector_cmp u_cmp_max (
        .a  (in_data),
        .b  (max_reg),
        .gt (x_gt),
        .lt (x_lt),
        .eq (x_eq)
    );

    frame_peak_detector_cmp u_cmp_min (
        .a  (in_data),
        .b  (min_reg),
        .gt (n_gt),
        .lt (n_lt),
        .eq (n_eq)
    );

    assign in_ready      = (state != DONE);
    assign out_max       = max_reg;
    assign out_min       = min_reg;
    assign out_max_count = max_count;

    always_comb begin
        state_nxt      = state;
        max_nxt        = max_reg;
        min_nxt        = min_reg;
        max_count_nxt  = max_count;
        sample_cnt_nxt = sample_cnt;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    max_nxt        = in_data;
                    min_nxt        = in_data;
                    max_count_nxt  = CNT_W'(1);
                    sample_cnt_nxt = CNT_W'(1);
                    state_nxt      = (FRAME_LEN == 1) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    case (1'b1)
                        x_gt: begin
                            max_nxt       = in_data;
                            max_count_nxt = CNT_W'(1);
                        end
                        x_eq:    max_count_nxt = max_count + CNT_W'(1);
                        x_lt:    max_count_nxt = max_count;
                        default: max_count_nxt = max_count;
                    endcase
                    case (1'b1)
                        n_lt:       min_nxt = in_data;
                        n_gt, n_eq: min_nxt = min_reg;
                        default:    min_nxt = min_reg;
                    endcase
                    sample_cnt_nxt = sample_cnt + CNT_W'(1);
                    if (sample_cnt_nxt == FRAME_LEN_C) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // clear overrides everything above, including a sample offered this cycle
        if (clear) begin
            state_nxt      = IDLE;
            max_nxt        = '0;
            min_nxt        = '0;
            max_count_nxt  = '0;
            sample_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            max_reg    <= '0;
            min_reg    <= '0;
            max_count  <= '0;
            sample_cnt <= '0;
        end else begin
            state      <= state_nxt;
            out_valid  <= (state_nxt == DONE);
            max_reg    <= max_nxt;
            min_reg    <= min_nxt;
            max_count  <= max_count_nxt;
            sample_cnt <= sample_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_frame_peak_detector.sv
// Directed bench for frame_peak_detector with FRAME_LEN = 4 and FRAME_LEN = 1.
module tb_frame_peak_detector;

    logic        clk = 1'b0;
    logic        n_rst;

    logic        clear4, in_valid4, out_ready4;
    logic [15:0] in_data4;
    logic        in_ready4, out_valid4;
    logic [15:0] out_max4, out_min4, out_cnt4;

    logic        clear1, in_valid1, out_ready1;
    logic [15:0] in_data1;
    logic        in_ready1, out_valid1;
    logic [15:0] out_max1, out_min1, out_cnt1;

    int unsigned tests = 0;
    int unsigned fails = 0;

    always #5 clk = ~clk;

    frame_peak_detector #(.FRAME_LEN(4)) dut4 (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (clear4),
        .in_valid      (in_valid4),
        .in_data       (in_data4),
        .in_ready      (in_ready4),
        .out_valid     (out_valid4),
        .out_ready     (out_ready4),
        .out_max       (out_max4),
        .out_min       (out_min4),
        .out_max_count (out_cnt4)
    );

    frame_peak_detector #(.FRAME_LEN(1)) dut1 (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (clear1),
        .in_valid      (in_valid1),
        .in_data       (in_data1),
        .in_ready      (in_ready1),
        .out_valid     (out_valid1),
        .out_ready     (out_ready1),
        .out_max       (out_max1),
        .out_min       (out_min1),
        .out_max_count (out_cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick(input int unsigned n = 1);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send4(input logic [15:0] d, input int unsigned gap = 0);
        in_valid4 = 1'b1;
        in_data4  = d;
        tick();
        in_valid4 = 1'b0;
        if (gap != 0) tick(gap);
    endtask

    task automatic chk_res4(input string tag, input logic [15:0] mx, input logic [15:0] mn,
                            input logic [15:0] cnt);
        chk({tag, "_valid"}, {31'd0, out_valid4}, 32'd1);
        chk({tag, "_ready"}, {31'd0, in_ready4}, 32'd0);
        chk({tag, "_max"}, {16'd0, out_max4}, {16'd0, mx});
        chk({tag, "_min"}, {16'd0, out_min4}, {16'd0, mn});
        chk({tag, "_cnt"}, {16'd0, out_cnt4}, {16'd0, cnt});
    endtask

    task automatic pop4(input string tag);
        out_ready4 = 1'b1;
        tick();
        out_ready4 = 1'b0;
        chk({tag, "_pop_valid"}, {31'd0, out_valid4}, 32'd0);
        chk({tag, "_pop_ready"}, {31'd0, in_ready4}, 32'd1);
    endtask

    initial begin
        n_rst = 1'b0;
        clear4 = 1'b0; in_valid4 = 1'b0; in_data4 = '0; out_ready4 = 1'b0;
        clear1 = 1'b0; in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
        #2;
        chk("rst_ready", {31'd0, in_ready4}, 32'd1);
        chk("rst_valid", {31'd0, out_valid4}, 32'd0);
        chk("rst_max", {16'd0, out_max4}, 32'd0);
        chk("rst_min", {16'd0, out_min4}, 32'd0);
        chk("rst_cnt", {16'd0, out_cnt4}, 32'd0);
        tick(2);
        n_rst = 1'b1;
        tick();

        // basic frame 5, 9, 9, 2
        send4(16'd5);
        send4(16'd9);
        send4(16'd9);
        chk("f1_valid_early", {31'd0, out_valid4}, 32'd0);
        send4(16'd2);
        chk_res4("f1", 16'd9, 16'd2, 16'd2);

        // backpressure: a sample offered while DONE must not be consumed
        in_valid4 = 1'b1;
        in_data4  = 16'd100;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_res4("hold", 16'd9, 16'd2, 16'd2);
        end
        out_ready4 = 1'b1;
        tick();
        out_ready4 = 1'b0;
        in_valid4  = 1'b0;
        chk("hold_pop_valid", {31'd0, out_valid4}, 32'd0);
        chk("hold_pop_ready", {31'd0, in_ready4}, 32'd1);
        chk("idle_keeps_max", {16'd0, out_max4}, 32'd9);
        send4(16'd1);
        send4(16'd2);
        send4(16'd3);
        send4(16'd4);
        chk_res4("f2", 16'd4, 16'd1, 16'd1);
        pop4("f2");

        // extremes with in_valid gaps
        send4(16'hFFFF, 0);
        send4(16'h0000, 3);
        send4(16'hFFFF, 1);
        send4(16'hFFFF, 2);
        chk_res4("f3", 16'hFFFF, 16'h0000, 16'd3);
        pop4("f3");

        // clear after two samples, with a sample offered in the clear cycle
        send4(16'd50);
        send4(16'd1);
        clear4    = 1'b1;
        in_valid4 = 1'b1;
        in_data4  = 16'd200;
        tick();
        clear4    = 1'b0;
        in_valid4 = 1'b0;
        chk("clr_max", {16'd0, out_max4}, 32'd0);
        chk("clr_min", {16'd0, out_min4}, 32'd0);
        chk("clr_cnt", {16'd0, out_cnt4}, 32'd0);
        chk("clr_ready", {31'd0, in_ready4}, 32'd1);
        send4(16'd7);
        send4(16'd3);
        send4(16'd7);
        send4(16'd8);
        chk_res4("f4", 16'd8, 16'd3, 16'd1);

        // clear while DONE drops the pending result
        clear4 = 1'b1;
        tick();
        clear4 = 1'b0;
        chk("clr_done_valid", {31'd0, out_valid4}, 32'd0);
        chk("clr_done_ready", {31'd0, in_ready4}, 32'd1);
        chk("clr_done_max", {16'd0, out_max4}, 32'd0);

        // asynchronous reset mid-frame
        send4(16'd10);
        send4(16'd20);
        n_rst = 1'b0;
        #1;
        chk("arst_mid_max", {16'd0, out_max4}, 32'd0);
        chk("arst_mid_min", {16'd0, out_min4}, 32'd0);
        chk("arst_mid_cnt", {16'd0, out_cnt4}, 32'd0);
        chk("arst_mid_ready", {31'd0, in_ready4}, 32'd1);
        tick();
        n_rst = 1'b1;
        tick();
        send4(16'd3);
        send4(16'd3);
        send4(16'd3);
        send4(16'd3);
        chk_res4("f5", 16'd3, 16'd3, 16'd4);

        // asynchronous reset while a result is pending
        n_rst = 1'b0;
        #1;
        chk("arst_done_valid", {31'd0, out_valid4}, 32'd0);
        chk("arst_done_max", {16'd0, out_max4}, 32'd0);
        chk("arst_done_cnt", {16'd0, out_cnt4}, 32'd0);
        chk("arst_done_ready", {31'd0, in_ready4}, 32'd1);
        tick();
        n_rst = 1'b1;
        tick();
        send4(16'd6);
        send4(16'd5);
        send4(16'd4);
        send4(16'd6);
        chk_res4("f6", 16'd6, 16'd4, 16'd2);
        pop4("f6");

        // FRAME_LEN = 1: every sample is a complete frame
        out_ready1 = 1'b1;
        in_valid1  = 1'b1;
        in_data1   = 16'd42;
        tick();
        in_data1 = 16'd17;
        chk("l1a_valid", {31'd0, out_valid1}, 32'd1);
        chk("l1a_ready", {31'd0, in_ready1}, 32'd0);
        chk("l1a_max", {16'd0, out_max1}, 32'd42);
        chk("l1a_min", {16'd0, out_min1}, 32'd42);
        chk("l1a_cnt", {16'd0, out_cnt1}, 32'd1);
        tick();
        chk("l1a_gap_valid", {31'd0, out_valid1}, 32'd0);
        chk("l1a_gap_ready", {31'd0, in_ready1}, 32'd1);
        tick();
        in_valid1 = 1'b0;
        chk("l1b_valid", {31'd0, out_valid1}, 32'd1);
        chk("l1b_ready", {31'd0, in_ready1}, 32'd0);
        chk("l1b_max", {16'd0, out_max1}, 32'd17);
        chk("l1b_min", {16'd0, out_min1}, 32'd17);
        chk("l1b_cnt", {16'd0, out_cnt1}, 32'd1);
        tick();
        chk("l1b_gap_valid", {31'd0, out_valid1}, 32'd0);
        chk("l1b_gap_ready", {31'd0, in_ready1}, 32'd1);
        out_ready1 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/frame_peak_detector.md
# frame_peak_detector

- Accepts a stream of unsigned 16-bit samples over a valid/ready handshake.
- Groups samples into frames of FRAME_LEN samples and tracks, per frame, the maximum, the minimum, and how many samples equal the final maximum.
- Sits directly downstream of the 16-bit magnitude comparator:
  - drives the comparator's a/b inputs with the incoming sample and the running extremes;
  - consumes its gt/lt/eq results in the same cycle.
- Presents one result per frame on an output valid/ready handshake.

## Interface
- FRAME_LEN, default 8: samples per frame. Legal range 1..65535.
- clk  input  1: single clock. All state changes on the rising edge.
- n_rst  input  1: asynchronous, active-low reset.
- clear  input  1: synchronous frame abort. Highest priority after reset.
- in_valid  input  1: in_data is valid this cycle.
- in_data  input  16: unsigned sample.
- in_ready  output  1: the block can accept a sample. Combinational from state.
- out_valid  output  1: the frame result is valid. Registered.
- out_ready  input  1: the consumer accepts the result.
- out_max  output  16: frame maximum.
- out_min  output  16: frame minimum.
- out_max_count  output  16: number of samples in the frame equal to out_max.

## Operation
- A transfer occurs on a rising edge where in_valid && in_ready.
- A result is taken on a rising edge where out_valid && out_ready.
- FSM states: IDLE, ACCUM, DONE. in_ready = 1 in IDLE and ACCUM, 0 in DONE.
- IDLE, on transfer:
  - max_reg = min_reg = in_data, max_count = 1, sample_cnt = 1.
  - Go to ACCUM, or to DONE if FRAME_LEN == 1.
- ACCUM, on transfer, using two comparator instances:
  - Instance X: a = in_data, b = max_reg. Instance N: a = in_data, b = min_reg.
  - X.gt: max_reg = in_data, max_count = 1.
  - X.eq: max_count += 1.
  - X.lt: max_reg and max_count unchanged.
  - N.lt: min_reg = in_data. Otherwise min_reg is unchanged.
  - sample_cnt += 1. When the new sample_cnt == FRAME_LEN, go to DONE.
- ACCUM with no transfer: all registers hold. Gaps in in_valid are legal and unlimited.
- DONE:
  - out_valid = 1. No samples are accepted.
  - On out_ready, go to IDLE. out_valid drops after that edge.
- out_max, out_min and out_max_count are the running registers.
  - They are only meaningful while out_valid = 1.
  - In IDLE they keep the last frame's values until the next frame's first transfer.
- All compares are unsigned, 16-bit. max_count cannot overflow because it is at most FRAME_LEN.
- clear = 1 at an edge, in any state:
  - state goes to IDLE; out_valid, sample_cnt, max_reg, min_reg and max_count go to 0;
  - any sample offered that cycle is discarded, even if in_ready was 1;
  - a pending result in DONE is dropped.

## Timing
- Reset (n_rst = 0, asynchronous): state IDLE, out_valid 0, out_max 0, out_min 0, out_max_count 0, internal counters 0.
- in_ready reads 1 during and after reset.
- Latency: the edge that accepts the FRAME_LENth sample also registers the final extremes. out_valid = 1 is visible immediately after that edge.
- Back-to-back frames: DONE → IDLE costs one cycle with in_ready = 0.
  - With out_ready held at 1, throughput is FRAME_LEN samples per FRAME_LEN + 1 cycles.
- out_valid and all out_* values are stable while out_valid = 1 and out_ready = 0.
- Reset mid-frame: the partial frame is lost and the next transfer starts a new frame.
- The comparator path is combinational within one cycle: in_data → compare → register update.

## Structure
- Package frame_peak_pkg:
  - DATA_W = 16;
  - state_t enum {IDLE, ACCUM, DONE};
  - CNT_W = 16.
- Sub-module: two instances of the existing 16-bit comparator (inputs a, b; outputs gt, lt, eq).
- Everything else is local.

## Test plan
- Reset, then FRAME_LEN = 4, samples 5, 9, 9, 2 → out_valid 1 after the 4th edge, out_max 9, out_min 2, out_max_count 2.
- Same frame with out_ready low for 3 cycles → outputs held, in_ready 0, no sample consumed. out_ready high → IDLE next cycle, next frame starts cleanly.
- Samples 0xFFFF, 0x0000, 0xFFFF, 0xFFFF with in_valid gaps of 0–3 cycles → out_max 0xFFFF, out_min 0x0000, out_max_count 3.
- clear pulsed after 2 of 4 samples, then 4 new samples 7, 3, 7, 8 → result is max 8, min 3, count 1, with no leakage from the aborted samples.
- n_rst asserted mid-frame and while out_valid = 1 → all outputs 0 immediately; after release in_ready = 1 and a fresh frame completes correctly.
- FRAME_LEN = 1, samples 42 then 17 → two results, (42, 42, 1) then (17, 17, 1), each followed by one in_ready = 0 cycle.
